// File: rtl/exa_crosb_out_arbiter.sv
// Per-output packet arbiter for the ExaNet crossbar: round-robin grant held until the LAST beat.
// Optional high-priority class with starvation guard is enabled by defining EXA_ARB_PRIO_EN.

module exa_crosb_out_arbiter_lane (
  input  logic       req_i,
  input  logic       prio_i,
  input  logic [1:0] mode_i,
  output logic       cand_o
);
  // mode 0: any request, 1: high-priority only, 2: low-priority only
  always_comb begin
    cand_o = req_i;
    case (mode_i)
      2'd1:    cand_o = req_i & prio_i;
      2'd2:    cand_o = req_i & ~prio_i;
      default: cand_o = req_i;
    endcase
  end
endmodule

module exa_crosb_out_arbiter #(
  parameter int INPUT_NUM    = 16,
  parameter int SEL_WIDTH    = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INPUT_NUM-1:0] REQ_i,
  input  logic [INPUT_NUM-1:0] PRIO_i,
  input  logic [INPUT_NUM-1:0] VALID_i,
  input  logic [INPUT_NUM-1:0] LAST_i,
  input  logic                 READY_i,
  output logic [SEL_WIDTH-1:0] SEL_o,
  output logic [INPUT_NUM-1:0] GRANT_o,
  output logic                 LOCKED_o
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  localparam logic [1:0] M_REQ = 2'd0;
  localparam logic [1:0] M_HI  = 2'd1;
  localparam logic [1:0] M_LO  = 2'd2;

  logic [0:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [INPUT_NUM-1:0] grant_q, grant_d;
  logic [INPUT_NUM-1:0] cand;
  logic [1:0]           mode;
  logic [SEL_WIDTH-1:0] win_idx;
  logic                 win_found;

  for (genvar g = 0; g < INPUT_NUM; g++) begin : g_lane
    exa_crosb_out_arbiter_lane u_lane (
      .req_i (REQ_i[g]),
      .prio_i(PRIO_i[g]),
      .mode_i(mode),
      .cand_o(cand[g])
    );
  end

  // First candidate strictly after the pointer, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= INPUT_NUM; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % INPUT_NUM;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = SEL_WIDTH'(idx);
      end
    end
  end

`ifdef EXA_ARB_PRIO_EN
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             hi_any, lo_any, at_limit;

  always_comb begin
    hi_any   = |(REQ_i & PRIO_i);
    lo_any   = |(REQ_i & ~PRIO_i);
    at_limit = (starve_q == CNT_W'(STARVE_LIMIT));
    if (at_limit && lo_any) mode = M_LO;
    else if (hi_any)        mode = M_HI;
    else                    mode = M_REQ;

    starve_d = starve_q;
    if (state_q == S_IDLE && win_found) begin
      if (at_limit || !PRIO_i[win_idx]) starve_d = '0;
      else if (lo_any)                  starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  localparam int starve_unused = STARVE_LIMIT;
  assign mode = M_REQ;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_LOCKED;
          sel_d   = win_idx;
          ptr_d   = win_idx;
          grant_d = INPUT_NUM'(1) << win_idx;
        end
      end
      S_LOCKED: begin
        // REQ/PRIO are deliberately ignored: only the LAST transfer releases
        if (VALID_i[sel_q] && READY_i && LAST_i[sel_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ptr_q   <= SEL_WIDTH'(INPUT_NUM - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign SEL_o    = sel_q;
  assign GRANT_o  = grant_q;
  assign LOCKED_o = (state_q == S_LOCKED);

endmodule

// File: tb/tb_exa_crosb_out_arbiter.sv
// Directed bench for exa_crosb_out_arbiter with 4 inputs; priority scenario depends on EXA_ARB_PRIO_EN.
module tb_exa_crosb_out_arbiter;
  logic       clk;
  logic       reset;
  logic [3:0] req, prio, valid, last;
  logic       ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       locked;

  int total = 0;
  int bad   = 0;

  exa_crosb_out_arbiter #(.INPUT_NUM(4), .STARVE_LIMIT(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .REQ_i   (req),
    .PRIO_i  (prio),
    .VALID_i (valid),
    .LAST_i  (last),
    .READY_i (ready),
    .SEL_o   (sel),
    .GRANT_o (grant),
    .LOCKED_o(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the bench at a falling edge with reset released and all inputs idle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0; prio = '0; valid = '0; last = '0; ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req = 4'b1111; prio = '0; valid = '0; last = '0; ready = 1'b0;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b0, 4'b0000, 2'd0}) begin
      bad++;
      $display("FAIL reset_state: got l=%b g=%b s=%0d want l=0 g=0000 s=0", locked, grant, sel);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b1, 4'b0001, 2'd0}) begin
      bad++;
      $display("FAIL reset_release_grant: got l=%b g=%b s=%0d want l=1 g=0001 s=0", locked, grant, sel);
    end
  endtask

  task automatic test_rr_wrap();
    logic       el;
    logic [1:0] es;
    logic [3:0] eg;
    do_reset();
    req = 4'b1111; valid = 4'b1111; last = 4'b1111; ready = 1'b1;
    es = 2'd0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      el = (k % 2 == 0);
      if (el) es = 2'((k / 2) % 4);
      eg = el ? (4'b0001 << es) : 4'b0000;
      total++;
      if ({locked, grant, sel} !== {el, eg, es}) begin
        bad++;
        $display("FAIL rr_wrap[%0d]: got l=%b g=%b s=%0d want l=%b g=%b s=%0d",
                 k, locked, grant, sel, el, eg, es);
      end
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b1, 4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL lock_grant2: got l=%b g=%b s=%0d want l=1 g=0100 s=2", locked, grant, sel);
    end
    // beat 1 transfers; request vector changes under the lock
    valid = 4'b0100; ready = 1'b1; last = 4'b0000; req = 4'b1011;
    @(negedge clk);
    // beat 2 stalled; a LAST on a non-granted input must not release
    valid = 4'b0101; last = 4'b0001; ready = 1'b0; req = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({locked, grant, sel} !== {1'b1, 4'b0100, 2'd2}) begin
        bad++;
        $display("FAIL lock_stall[%0d]: got l=%b g=%b s=%0d want l=1 g=0100 s=2", k, locked, grant, sel);
      end
      req = 4'b1000;
    end
    ready = 1'b1;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b1, 4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL lock_beat2: got l=%b g=%b s=%0d want l=1 g=0100 s=2", locked, grant, sel);
    end
    valid = 4'b0100; last = 4'b0100;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b0, 4'b0000, 2'd2}) begin
      bad++;
      $display("FAIL lock_release: got l=%b g=%b s=%0d want l=0 g=0000 s=2", locked, grant, sel);
    end
    valid = 4'b0000; last = 4'b0000;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b1, 4'b1000, 2'd3}) begin
      bad++;
      $display("FAIL lock_next_grant: got l=%b g=%b s=%0d want l=1 g=1000 s=3", locked, grant, sel);
    end
  endtask

  task automatic test_drop_req();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b1, 4'b0010, 2'd1}) begin
      bad++;
      $display("FAIL drop_grant1: got l=%b g=%b s=%0d want l=1 g=0010 s=1", locked, grant, sel);
    end
    req = 4'b0000; valid = 4'b0010; ready = 1'b1; last = 4'b0000;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b1, 4'b0010, 2'd1}) begin
      bad++;
      $display("FAIL drop_held: got l=%b g=%b s=%0d want l=1 g=0010 s=1", locked, grant, sel);
    end
    last = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({locked, grant, sel} !== {1'b0, 4'b0000, 2'd1}) begin
        bad++;
        $display("FAIL drop_release[%0d]: got l=%b g=%b s=%0d want l=0 g=0000 s=1", k, locked, grant, sel);
      end
    end
  endtask

  task automatic test_prio();
    logic [1:0] ord [4];
    logic       el;
    logic [1:0] es;
    logic [3:0] eg;
`ifdef EXA_ARB_PRIO_EN
    ord[0] = 2'd1; ord[1] = 2'd3; ord[2] = 2'd0; ord[3] = 2'd1;
`else
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd3; ord[3] = 2'd0;
`endif
    do_reset();
    req = 4'b1011; prio = 4'b1010; valid = 4'b1111; last = 4'b1111; ready = 1'b1;
    es = 2'd0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      el = (k % 2 == 0);
      if (el) es = ord[k / 2];
      eg = el ? (4'b0001 << es) : 4'b0000;
      total++;
      if ({locked, grant, sel} !== {el, eg, es}) begin
        bad++;
        $display("FAIL prio_order[%0d]: got l=%b g=%b s=%0d want l=%b g=%b s=%0d",
                 k, locked, grant, sel, el, eg, es);
      end
`ifdef EXA_ARB_PRIO_EN
      if (k == 4) begin
        total++;
        if (dut.starve_q !== 2'd0) begin
          bad++;
          $display("FAIL prio_starve_clear: got cnt=%0d want 0", dut.starve_q);
        end
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    valid = 4'b0100; ready = 1'b1; last = 4'b0000;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b1, 4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL areset_pre: got l=%b g=%b s=%0d want l=1 g=0100 s=2", locked, grant, sel);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({locked, grant, sel} !== {1'b0, 4'b0000, 2'd0}) begin
      bad++;
      $display("FAIL areset_immediate: got l=%b g=%b s=%0d want l=0 g=0000 s=0", locked, grant, sel);
    end
    @(negedge clk);
    req = 4'b0110; valid = '0;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({locked, grant, sel} !== {1'b1, 4'b0010, 2'd1}) begin
      bad++;
      $display("FAIL areset_regrant: got l=%b g=%b s=%0d want l=1 g=0010 s=1", locked, grant, sel);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0; prio = '0; valid = '0; last = '0; ready = 1'b0;
    test_reset();
    test_rr_wrap();
    test_packet_lock();
    test_drop_req();
    test_prio();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exa_crosb_out_arbiter.md
# exa_crosb_out_arbiter

Per-output packet arbiter for the ExaNet crossbar. It sits directly upstream of the crossbar output mux and drives that mux's select lines. It picks one requesting input port round-robin, optionally favouring high-priority traffic. It holds the grant for the whole packet, until the LAST beat is accepted downstream.

## Interface
- `input_num`, 16, number of crossbar inputs competing for this output.
- `sel_width`, `log2(input_num)`, width of the select index.
- `starve_limit`, 4, maximum consecutive high-priority grants while a low-priority request is pending (used only with `EXA_ARB_PRIO_EN`).

- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `REQ_i`  in  input_num  bit i high means input i holds a packet for this output.
- `PRIO_i`  in  input_num  bit i high means input i's pending packet is high priority.
- `VALID_i`  in  input_num  per-input beat valid.
- `LAST_i`  in  input_num  per-input last-beat flag.
- `READY_i`  in  1  downstream accepts the selected beat this cycle.
- `SEL_o`  out  sel_width  index of the granted input; feeds the mux select.
- `GRANT_o`  out  input_num  one-hot grant; all zero when unlocked.
- `LOCKED_o`  out  1  a packet is in flight on this output.

## Operation
- Two states: IDLE and LOCKED.
- Reset values: state IDLE, `SEL_o`=0, `GRANT_o`=0, `LOCKED_o`=0, rr pointer `ptr`=input_num-1, starvation counter=0.
- IDLE behaviour:
  - If `REQ_i` is nonzero, select a winner, register it into `SEL_o`/`GRANT_o`, set `ptr` to the winner and go to LOCKED.
  - With `REQ_i`=0, stay in IDLE; `SEL_o` holds its last value.
- Winner selection: the first set bit of the candidate vector, searching indices ptr+1, ptr+2, … modulo input_num (wrap-around). The candidate vector is `REQ_i`, or as modified by the priority rules in Configuration.
- LOCKED behaviour:
  - A transfer is `VALID_i[SEL_o] && READY_i`.
  - A transfer with `LAST_i[SEL_o]`=1 returns the block to IDLE and clears `GRANT_o` and `LOCKED_o`.
  - Any other cycle keeps the grant.
  - `REQ_i` and `PRIO_i` are ignored while LOCKED. A requester dropping REQ mid-packet does not release the lock.
- Single-beat packet: VALID and LAST on the first beat, with READY, releases after one transfer.
- Reset asserted mid-packet clears everything immediately (async); no partial-packet recovery.

## Timing
- Arbitration latency: `REQ_i` sampled in IDLE at cycle t produces a valid `GRANT_o`/`SEL_o`/`LOCKED_o` at t+1.
- The first beat can transfer at t+1.
- LAST transfer at cycle t: unlocked at t+1. The next arbitration samples at t+1 and the new grant appears at t+2. This gives exactly one idle cycle between packets.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `GRANT_o` is always one-hot or zero, and equals 1<<`SEL_o` whenever `LOCKED_o`=1.

## Configuration
- Macro: `EXA_ARB_PRIO_EN`.
- Defined:
  - The candidate vector is `REQ_i & PRIO_i` if that is nonzero, else `REQ_i`.
  - One shared rr pointer is used for both classes.
  - Starvation counter:
    - Increments on each high-priority grant made while some low-priority request (`REQ_i & ~PRIO_i`) is pending.
    - Clears on any low-priority grant.
    - When it equals `starve_limit`, the next arbitration uses `REQ_i & ~PRIO_i` as candidates and the counter clears.
  - Counter width is `log2(starve_limit+1)`; it saturates, never wraps.
- Undefined: `PRIO_i` is ignored, plain round-robin on `REQ_i`, and no counter logic is synthesised.

## Test plan
Each scenario uses input_num=4.
- Reset release with `REQ_i`=4'b1111 and no transfers: one cycle later `SEL_o`=0, `GRANT_o`=4'b0001, `LOCKED_o`=1.
- Round-robin wrap: `REQ_i`=4'b1111, 1-beat packets, READY=1 constant. Grant order is 0,1,2,3,0, with one unlocked cycle between consecutive grants.
- Packet lock: input 2 granted, 3-beat packet with READY low on beat 2 for 2 cycles, `REQ_i` changing meanwhile. `SEL_o` stays 2 until the LAST transfer and unlocks the next cycle.
- Drop request mid-packet: input 1 granted, `REQ_i[1]` deasserted before LAST. The lock is held and releases only on the LAST transfer.
- With `EXA_ARB_PRIO_EN`, `starve_limit`=2:
  - Stimulus: `REQ_i`=4'b1011, `PRIO_i`=4'b1010.
  - Grant order: 1, 3, 0, then 1.
  - The third grant goes to low-priority input 0, forced by the starvation counter; the counter is zero afterward.
- Async reset asserted in LOCKED mid-packet: all outputs are zero within the same cycle. After release, the first grant goes to the lowest requesting index.
